// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
package mips_pkg;

    // Sequencer states; the encoding is visible on the state output.
    typedef enum logic [1:0] {
        FILL     = 2'd0,
        HALTED   = 2'd1,
        RUNNING  = 2'd2,
        STEPPING = 2'd3
    } seq_state_t;

    // EX operand source selects.
    localparam logic [1:0] FWD_REG = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // result being written back
    localparam logic [1:0] FWD_MEM = 2'b10;  // ALU result held in EX/MEM

    // $zero is hardwired, so it never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/forwarding_unit.sv
// Operand bypass select for one EX-stage source register.
// MEM wins over WB because it holds the younger result.
module forwarding_unit
    import mips_pkg::*;
(
    input  logic [4:0] srcReg,
    input  logic       memRegWrite,
    input  logic [4:0] memWriteReg,
    input  logic       wbRegWrite,
    input  logic [4:0] wbWriteReg,
    input  logic       wbSuppress,
    output logic [1:0] fwdSel
);

    logic memHit;
    logic wbHit;

    assign memHit = memRegWrite & (memWriteReg != REG_ZERO) & (memWriteReg == srcReg);
    // A suppressed writeback is not a real result, so it must not be bypassed.
    assign wbHit  = wbRegWrite & (wbWriteReg != REG_ZERO) & (wbWriteReg == srcReg) & ~wbSuppress;

    // Priority select: MEM result, then WB result, then register file.
    always_comb begin
        fwdSel = FWD_REG;
        if (memHit) begin
            fwdSel = FWD_MEM;
        end else if (wbHit) begin
            fwdSel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Central sequencer for the 5-stage pipeline: run/halt/step control,
// post-reset fill with writeback suppressed, load-use stall detection,
// EX forwarding selects and performance counters.
module pipeline_sequencer
    import mips_pkg::*;
#(
    parameter int FILL_CYCLES  = 4,
    parameter bit START_HALTED = 1'b0,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run_req,
    input  logic                   halt_req,
    input  logic                   step_req,
    input  logic                   clr_counters,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_uses_rt,
    input  logic [4:0]             ex_rs,
    input  logic [4:0]             ex_rt,
    input  logic                   ex_mem_to_reg,
    input  logic                   ex_reg_write,
    input  logic [4:0]             ex_write_reg,
    input  logic                   mem_reg_write,
    input  logic [4:0]             mem_write_reg,
    input  logic                   wb_reg_write,
    input  logic [4:0]             wb_write_reg,
    output logic                   pipe_en,
    output logic                   if_stall,
    output logic                   ex_bubble,
    output logic                   wb_suppress,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   step_done,
    output logic [1:0]             state,
    output logic [31:0]            cycle_count,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [3:0] FILL_LAST = 4'(FILL_CYCLES - 1);

    seq_state_t             stateReg;
    seq_state_t             stateNext;
    logic [3:0]             fillCount;
    logic                   pipeEnReg;
    logic                   wbSuppressReg;
    logic                   stepDoneReg;
    logic [31:0]            cycleCount;
    logic [STALL_CNT_W-1:0] stallCount;

    logic loadInEx;
    logic rsMatch;
    logic rtMatch;
    logic hazard;
    logic stallNow;
    logic advancing;

    // Next-state decode; requests are ignored while the pipeline fills.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            FILL: begin
                if (fillCount == FILL_LAST) begin
                    stateNext = START_HALTED ? HALTED : RUNNING;
                end
            end
            HALTED: begin
                if (halt_req) begin
                    stateNext = HALTED;
                end else if (step_req) begin
                    stateNext = STEPPING;
                end else if (run_req) begin
                    stateNext = RUNNING;
                end
            end
            RUNNING: begin
                if (halt_req) begin
                    stateNext = HALTED;
                end
            end
            STEPPING: begin
                stateNext = HALTED;
            end
            default: begin
                stateNext = FILL;
            end
        endcase
    end

    // State register with outputs registered from the next state so they
    // change together with the state and never glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg      <= FILL;
            fillCount     <= 4'd0;
            pipeEnReg     <= 1'b1;
            wbSuppressReg <= 1'b1;
            stepDoneReg   <= 1'b0;
        end else begin
            stateReg      <= stateNext;
            if (stateReg == FILL) begin
                fillCount <= fillCount + 4'd1;
            end
            pipeEnReg     <= (stateNext != HALTED);
            wbSuppressReg <= (stateNext == FILL) || (stateNext == HALTED);
            stepDoneReg   <= (stateNext == STEPPING);
        end
    end

    // Load-use hazard: a load in EX whose destination feeds the ID instruction.
    assign loadInEx = ex_mem_to_reg & ex_reg_write & (ex_write_reg != REG_ZERO);
    assign rsMatch  = (ex_write_reg == id_rs);
    assign rtMatch  = id_uses_rt & (ex_write_reg == id_rt);
    assign hazard   = loadInEx & (rsMatch | rtMatch);

    // A frozen pipeline cannot stall, and fill-phase garbage is never a hazard.
    assign stallNow  = hazard & pipeEnReg & (stateReg != FILL);
    assign advancing = pipeEnReg & (stateReg != FILL);

    // Performance counters; clear takes priority over counting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycleCount <= 32'd0;
            stallCount <= '0;
        end else if (clr_counters) begin
            cycleCount <= 32'd0;
            stallCount <= '0;
        end else begin
            if (advancing) begin
                cycleCount <= cycleCount + 32'd1;
            end
            if (stallNow && (stallCount != {STALL_CNT_W{1'b1}})) begin
                stallCount <= stallCount + STALL_CNT_W'(1);
            end
        end
    end

    forwarding_unit fwdUnitA (
        .srcReg      (ex_rs),
        .memRegWrite (mem_reg_write),
        .memWriteReg (mem_write_reg),
        .wbRegWrite  (wb_reg_write),
        .wbWriteReg  (wb_write_reg),
        .wbSuppress  (wbSuppressReg),
        .fwdSel      (fwd_a)
    );

    forwarding_unit fwdUnitB (
        .srcReg      (ex_rt),
        .memRegWrite (mem_reg_write),
        .memWriteReg (mem_write_reg),
        .wbRegWrite  (wb_reg_write),
        .wbWriteReg  (wb_write_reg),
        .wbSuppress  (wbSuppressReg),
        .fwdSel      (fwd_b)
    );

    assign pipe_en     = pipeEnReg;
    assign wb_suppress = wbSuppressReg;
    assign step_done   = stepDoneReg;
    assign if_stall    = stallNow;
    assign ex_bubble   = stallNow;
    assign state       = stateReg;
    assign cycle_count = cycleCount;
    assign stall_count = stallCount;

endmodule
